// File: rtl/cmp_game_pkg.sv
// Shared types and constants for the compare-game controller: state enum,
// compare-flag payload, seven-segment glyphs and LEDR bit positions.
package cmp_game_pkg;

   localparam int unsigned NIB_W   = 4;
   localparam int unsigned TRIES_W = 4;
   localparam int unsigned SW_W    = 8;
   localparam int unsigned KEY_W   = 2;
   localparam int unsigned LEDR_W  = 10;
   localparam int unsigned HEX_W   = 8;

   localparam int unsigned LEDR_LT        = 0;
   localparam int unsigned LEDR_GT        = 1;
   localparam int unsigned LEDR_EQ        = 2;
   localparam int unsigned LEDR_TRIES_LSB = 4;
   localparam int unsigned LEDR_LOSE      = 8;
   localparam int unsigned LEDR_WIN       = 9;

   localparam logic [HEX_W-1:0] GLYPH_E     = 8'b1000_0110;
   localparam logic [HEX_W-1:0] GLYPH_L     = 8'b1100_0111;
   localparam logic [HEX_W-1:0] GLYPH_H     = 8'b1000_1001;
   localparam logic [HEX_W-1:0] GLYPH_BLANK = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GUESS = 3'd1,
      ST_SHOW  = 3'd2,
      ST_WIN   = 3'd3,
      ST_LOSE  = 3'd4
   } game_state_e;

   // Bit order matches ledr[2:0]: {equal, secret>guess, secret<guess}
   typedef struct packed {
      logic eq;
      logic gt;
      logic lt;
   } cmp_flags_t;

   function automatic cmp_flags_t cmp_nibble(input logic [NIB_W-1:0] secret,
                                             input logic [NIB_W-1:0] guess);
      cmp_flags_t f;
      f.eq = (secret == guess);
      f.gt = (secret > guess);
      f.lt = (secret < guess);
      return f;
   endfunction

   function automatic logic [HEX_W-1:0] glyph_of(input cmp_flags_t f);
      logic [HEX_W-1:0] g;
      if (f.eq)      g = GLYPH_E;
      else if (f.lt) g = GLYPH_H;
      else if (f.gt) g = GLYPH_L;
      else           g = GLYPH_BLANK;
      return g;
   endfunction

endpackage

// File: rtl/cmp_game_ctrl_if.sv
// Board-side bundle of the compare game: buttons and switches in, LED,
// status glyph and digit feeds out.
interface cmp_game_ctrl_if;
   import cmp_game_pkg::*;

   logic [KEY_W-1:0]  key_n;
   logic [SW_W-1:0]   sw;
   logic [LEDR_W-1:0] ledr;
   logic [HEX_W-1:0]  hex_status;
   logic [NIB_W-1:0]  secret_digit;
   logic [NIB_W-1:0]  guess_digit;
   logic              secret_show;

   modport master (
      output key_n, sw,
      input  ledr, hex_status, secret_digit, guess_digit, secret_show
   );

   modport slave (
      input  key_n, sw,
      output ledr, hex_status, secret_digit, guess_digit, secret_show
   );

endinterface

// File: rtl/key_pulse.sv
// Button conditioner: 2-flop synchronizer plus falling-edge detector giving a
// registered one-cycle strobe per press of an active-low key.
module key_pulse (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_n_i,
   output logic pulse_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic pulse_q;

   // Idle level of a released key is high, so reset the chain to 1
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         prev_q  <= 1'b1;
         pulse_q <= 1'b0;
      end else begin
         meta_q  <= key_n_i;
         sync_q  <= meta_q;
         prev_q  <= sync_q;
         pulse_q <= prev_q & ~sync_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/cmp_game_ctrl.sv
// Two-player nibble guessing game controller on top of the compare datapath.
// Optional CMP_SECRET_HIDE_EN blanks the secret display while guessing.
module cmp_game_ctrl
   import cmp_game_pkg::*;
#(
   parameter int unsigned MAX_TRIES   = 8,
   parameter int unsigned SHOW_CYCLES = 50_000_000
) (
   input  logic           MAX10_CLK1_50,
   input  logic           rst,
   cmp_game_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(SHOW_CYCLES);

   logic load_p;
   logic new_p;

   key_pulse u_key_load (
      .clk_i   (MAX10_CLK1_50),
      .rst_i   (rst),
      .key_n_i (bus.key_n[0]),
      .pulse_o (load_p)
   );

   key_pulse u_key_new (
      .clk_i   (MAX10_CLK1_50),
      .rst_i   (rst),
      .key_n_i (bus.key_n[1]),
      .pulse_o (new_p)
   );

   game_state_e        state_q, state_d;
   logic [NIB_W-1:0]   secret_q, secret_d;
   logic [NIB_W-1:0]   guess_q, guess_d;
   logic [TRIES_W-1:0] tries_q, tries_d;
   cmp_flags_t         flags_q, flags_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [LEDR_W-1:0]  ledr_q, ledr_d;
   logic [HEX_W-1:0]   hex_q, hex_d;
   logic [NIB_W-1:0]   digit_q, digit_d;
   logic               show_q, show_d;

   always_ff @(posedge MAX10_CLK1_50) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         secret_q <= '0;
         guess_q  <= '0;
         tries_q  <= '0;
         flags_q  <= '0;
         cnt_q    <= '0;
         ledr_q   <= '0;
         hex_q    <= GLYPH_BLANK;
         digit_q  <= '0;
         show_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         secret_q <= secret_d;
         guess_q  <= guess_d;
         tries_q  <= tries_d;
         flags_q  <= flags_d;
         cnt_q    <= cnt_d;
         ledr_q   <= ledr_d;
         hex_q    <= hex_d;
         digit_q  <= digit_d;
         show_q   <= show_d;
      end
   end

   // Next-state logic; outputs are decoded from next values so they land with the state
   always_comb begin
      state_d  = state_q;
      secret_d = secret_q;
      guess_d  = guess_q;
      tries_d  = tries_q;
      flags_d  = flags_q;
      cnt_d    = cnt_q;

      if (new_p) begin
         state_d = ST_IDLE;
         guess_d = '0;
         tries_d = '0;
         flags_d = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load_p) begin
                  secret_d = bus.sw[7:4];
                  tries_d  = '0;
                  state_d  = ST_GUESS;
               end
            end
            ST_GUESS: begin
               if (load_p) begin
                  guess_d = bus.sw[3:0];
                  if (tries_q != TRIES_W'(MAX_TRIES)) begin
                     tries_d = tries_q + 1'b1;
                  end
                  flags_d = cmp_nibble(secret_q, bus.sw[3:0]);
                  cnt_d   = CNT_W'(SHOW_CYCLES - 1);
                  state_d = ST_SHOW;
               end
            end
            ST_SHOW: begin
               if (cnt_q == '0) begin
                  if (flags_q.eq) begin
                     state_d = ST_WIN;
                  end else if (tries_q == TRIES_W'(MAX_TRIES)) begin
                     state_d = ST_LOSE;
                  end else begin
                     state_d = ST_GUESS;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: ;
         endcase
      end

      ledr_d                                  = '0;
      ledr_d[LEDR_EQ:LEDR_LT]                 = flags_d;
      ledr_d[LEDR_TRIES_LSB +: TRIES_W]       = tries_d;
      ledr_d[LEDR_LOSE]                       = (state_d == ST_LOSE);
      ledr_d[LEDR_WIN]                        = (state_d == ST_WIN);
      hex_d                                   = glyph_of(flags_d);
`ifdef CMP_SECRET_HIDE_EN
      show_d  = state_d inside {ST_IDLE, ST_WIN, ST_LOSE};
      digit_d = show_d ? secret_d : '0;
`else
      show_d  = 1'b1;
      digit_d = secret_d;
`endif
   end

   assign bus.ledr         = ledr_q;
   assign bus.hex_status   = hex_q;
   assign bus.secret_digit = digit_q;
   assign bus.guess_digit  = guess_q;
   assign bus.secret_show  = show_q;

endmodule
